key_matrix_if: RTL and testbench

- Keyboard-matrix responder on the far side of the MCU port interface.
- The MCU drives column strobes on its output port E. This block returns debounced row data for the MCU's input port A.
- On every debounced new key press it raises an active-low interrupt pulse on the MCU's _INT line.
- Sits at the MCU top level, between the raw switch matrix and the MCU port pins.

---
 rtl/key_matrix_if.sv | 181 ++++++++++++++++++
 tb/tb_key_matrix_if.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_if.sv
// key_matrix_if: debounced keyboard-matrix responder and press interrupt for the MCU ports.
// Build option KEY_CODE_EN adds a latched, priority-encoded last-press code on code_out.
module key_matrix_if #(
   parameter int SAMPLE_DIV = 4,
   parameter int DEBOUNCE   = 4,
   parameter int INT_LEN    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  col_sel,
   input  logic [15:0] keys,
   output logic [3:0]  row_out,
   output logic        int_n,
   output logic [3:0]  code_out
);
   localparam logic [3:0] PRESC_MAX = 4'(SAMPLE_DIV - 1);
   localparam logic [3:0] STAB_MAX  = 4'(DEBOUNCE);
   localparam logic [3:0] STAB_HIT  = 4'(DEBOUNCE - 1);
   localparam logic [7:0] INT_LOAD  = 8'(INT_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   logic [3:0]  prescaler;
   logic        tick;
   logic [15:0] prev_sample;
   logic [15:0] stable;
   logic [3:0]  stab_cnt;
   logic        accept;
   logic [15:0] new_keys;
   logic        press_evt;
   logic        pend;
   logic        pend_clr;
   logic [3:0]  row_nxt;
   state_t      state;
   state_t      state_nxt;
   logic [7:0]  int_cnt;
   logic [7:0]  int_cnt_nxt;
   logic        int_n_nxt;

   assign tick      = (prescaler == PRESC_MAX);
   // The DEBOUNCE-th consecutive equal tick is the only one that loads stable.
   assign accept    = tick && (keys == prev_sample) && (stab_cnt == STAB_HIT);
   assign new_keys  = keys & ~stable;
   assign press_evt = accept && (|new_keys);

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
      end else if (tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_sample <= '0;
         stab_cnt    <= '0;
         stable      <= '0;
      end else if (tick) begin
         prev_sample <= keys;
         if (keys != prev_sample) begin
            stab_cnt <= '0;
         end else if (stab_cnt < STAB_MAX) begin
            stab_cnt <= stab_cnt + 4'd1;
         end
         if (accept) begin
            stable <= keys;
         end
      end
   end

   always_comb begin
      row_nxt = '0;
      for (int c = 0; c < 4; c++) begin
         row_nxt = row_nxt | ({4{col_sel[c]}} & stable[c*4 +: 4]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_out <= '0;
      end else begin
         row_out <= row_nxt;
      end
   end

   // A press landing on the IDLE->PULSE edge keeps pend set so it is not lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= 1'b0;
      end else if (press_evt) begin
         pend <= 1'b1;
      end else if (pend_clr) begin
         pend <= 1'b0;
      end
   end

   always_comb begin
      state_nxt   = state;
      int_cnt_nxt = int_cnt;
      int_n_nxt   = int_n;
      pend_clr    = 1'b0;
      case (state)
         IDLE: begin
            int_n_nxt = 1'b1;
            if (pend) begin
               state_nxt   = PULSE;
               int_n_nxt   = 1'b0;
               int_cnt_nxt = INT_LOAD;
               pend_clr    = 1'b1;
            end
         end
         PULSE: begin
            int_n_nxt = 1'b0;
            if (int_cnt == 8'd0) begin
               state_nxt   = GAP;
               int_n_nxt   = 1'b1;
               int_cnt_nxt = INT_LOAD;
            end else begin
               int_cnt_nxt = int_cnt - 8'd1;
            end
         end
         GAP: begin
            int_n_nxt = 1'b1;
            if (int_cnt == 8'd0) begin
               state_nxt = IDLE;
            end else begin
               int_cnt_nxt = int_cnt - 8'd1;
            end
         end
         default: begin
            state_nxt   = IDLE;
            int_n_nxt   = 1'b1;
            int_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         int_cnt <= '0;
         int_n   <= 1'b1;
      end else begin
         state   <= state_nxt;
         int_cnt <= int_cnt_nxt;
         int_n   <= int_n_nxt;
      end
   end

`ifdef KEY_CODE_EN
   logic [3:0] code_nxt;

   // Descending scan so the lowest newly pressed index wins.
   always_comb begin
      code_nxt = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (new_keys[i]) begin
            code_nxt = 4'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         code_out <= '0;
      end else if (press_evt) begin
         code_out <= code_nxt;
      end
   end
`else
   assign code_out = 4'h0;
`endif

endmodule

// File: tb/tb_key_matrix_if.sv
// Self-checking bench for key_matrix_if: scenario tasks against a run-length/timeline reference model.
// Expected code_out follows the KEY_CODE_EN build option.
module tb_key_matrix_if;
   localparam int SD = 4;
   localparam int DB = 4;
   localparam int IL = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  col_sel = 4'h0;
   logic [15:0] keys = 16'h0000;
   logic [3:0]  row_out;
   logic        int_n;
   logic [3:0]  code_out;

   int checks = 0;
   int errors = 0;

   key_matrix_if #(.SAMPLE_DIV(SD), .DEBOUNCE(DB), .INT_LEN(IL)) dut (
      .clk      (clk),
      .reset    (reset),
      .col_sel  (col_sel),
      .keys     (keys),
      .row_out  (row_out),
      .int_n    (int_n),
      .code_out (code_out)
   );

   always #5 clk = ~clk;

   // Reference model: samples every SD-th clk, accepts a value once it has been seen
   // DB+1 times in a row, and schedules pulses on a timeline with a 2*IL+1 restart spacing.
   int          n = 0;
   int          run_len = 1;
   logic [15:0] run_val = 16'h0;
   logic [15:0] m_stable = 16'h0;
   logic [15:0] m_upd = 16'h0;
   logic        m_press = 1'b0;
   bit          m_pend = 1'b0;
   bit          started = 1'b0;
   int          last_start = 0;
   int          next_ok = 0;
   logic [3:0]  exp_row = 4'h0;
   logic        exp_int_n = 1'b1;
   logic [3:0]  exp_code = 4'h0;

   function automatic logic [3:0] rows_of(input logic [15:0] st, input logic [3:0] cs);
      logic [3:0] r;
      r = 4'h0;
      for (int c = 0; c < 4; c++) begin
         if (cs[c]) r = r | st[c*4 +: 4];
      end
      return r;
   endfunction

   function automatic logic [3:0] lowest(input logic [15:0] v);
      for (int i = 0; i < 16; i++) begin
         if (v[i]) return 4'(i);
      end
      return 4'h0;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         n = 0; run_len = 1; run_val = 16'h0; m_stable = 16'h0;
         m_pend = 1'b0; started = 1'b0; last_start = 0; next_ok = 0;
         exp_row = 4'h0; exp_int_n = 1'b1; exp_code = 4'h0;
      end else begin
         m_press = 1'b0;
         m_upd = m_stable;
         if (n % SD == SD - 1) begin
            if (keys == run_val) run_len++;
            else begin
               run_val = keys;
               run_len = 1;
            end
            if (run_len == DB + 1) begin
               m_upd = keys;
               m_press = |(keys & ~m_stable);
            end
         end
         exp_row = rows_of(m_stable, col_sel);
         if (m_pend && n >= next_ok) begin
            started = 1'b1;
            last_start = n;
            next_ok = n + 2 * IL + 1;
            m_pend = 1'b0;
         end
         if (m_press) begin
            m_pend = 1'b1;
`ifdef KEY_CODE_EN
            exp_code = lowest(keys & ~m_stable);
`endif
         end
         exp_int_n = !(started && (n - last_start) < IL);
         m_stable = m_upd;
         n++;
      end
   end

   task automatic do_reset(input int cyc);
      reset = 1'b1;
      repeat (cyc) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      keys = 16'hFFFF;
      col_sel = 4'hF;
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (row_out !== 4'h0 || int_n !== 1'b1 || code_out !== 4'h0) begin
            errors++;
            $display("FAIL reset_hold t=%0t row_out=%h int_n=%b code_out=%h want 0 1 0", $time, row_out, int_n, code_out);
         end
      end
      reset = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i < 16) begin
            checks++;
            if (row_out !== 4'h0) begin
               errors++;
               $display("FAIL reset_quiet clk=%0d row_out=%h want 0", i, row_out);
            end
         end
         checks++;
         if (row_out !== exp_row || int_n !== exp_int_n || code_out !== exp_code) begin
            errors++;
            $display("FAIL reset_model t=%0t got %h %b %h want %h %b %h", $time, row_out, int_n, code_out, exp_row, exp_int_n, exp_code);
         end
      end
   endtask

   task automatic test_clean_press();
      int rise, fall, low;
      logic [3:0] want_code;
`ifdef KEY_CODE_EN
      want_code = 4'd5;
`else
      want_code = 4'd0;
`endif
      keys = 16'h0000;
      col_sel = 4'b0010;
      do_reset(1);
      repeat ($urandom_range(0, 7)) @(negedge clk);
      keys = 16'h0020;
      rise = -1; fall = -1; low = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         checks++;
         if (row_out !== exp_row || int_n !== exp_int_n || code_out !== exp_code) begin
            errors++;
            $display("FAIL press_model t=%0t got %h %b %h want %h %b %h", $time, row_out, int_n, code_out, exp_row, exp_int_n, exp_code);
         end
         if (rise < 0 && row_out === 4'b0010) rise = i;
         if (fall < 0 && int_n === 1'b0) fall = i;
         if (int_n === 1'b0) low++;
      end
      // First sample tick lands 1..SD clks after the change, acceptance SD*DB clks later, row_out one more.
      checks++;
      if (rise < SD * DB + 2 || rise > SD * DB + SD + 1) begin
         errors++;
         $display("FAIL press_latency rise=%0d want %0d..%0d", rise, SD * DB + 2, SD * DB + SD + 1);
      end
      checks++;
      if (fall < 0 || rise < 0 || fall - rise < 0 || fall - rise > 2) begin
         errors++;
         $display("FAIL press_int_start fall=%0d rise=%0d want fall-rise in 0..2", fall, rise);
      end
      checks++;
      if (low != IL) begin
         errors++;
         $display("FAIL press_int_len low=%0d want %0d", low, IL);
      end
      checks++;
      if (code_out !== want_code) begin
         errors++;
         $display("FAIL press_code code_out=%h want %h", code_out, want_code);
      end
   endtask

   task automatic test_col_select();
      col_sel = 4'b0001;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (row_out !== 4'h0) begin
            errors++;
            $display("FAIL colsel_other row_out=%h want 0", row_out);
         end
      end
      col_sel = 4'b0010;
      @(negedge clk);
      checks++;
      if (row_out !== 4'b0010) begin
         errors++;
         $display("FAIL colsel_switch row_out=%h want 2", row_out);
      end
      for (int i = 0; i < 24; i++) begin
         col_sel = 4'($urandom);
         @(negedge clk);
         checks++;
         if (row_out !== exp_row || int_n !== exp_int_n || code_out !== exp_code) begin
            errors++;
            $display("FAIL colsel_model t=%0t got %h %b %h want %h %b %h", $time, row_out, int_n, code_out, exp_row, exp_int_n, exp_code);
         end
      end
      col_sel = 4'b0000;
      @(negedge clk);
      checks++;
      if (row_out !== 4'h0) begin
         errors++;
         $display("FAIL colsel_none row_out=%h want 0", row_out);
      end
   endtask

   task automatic test_bounce();
      keys = 16'h0000;
      col_sel = 4'b0001;
      do_reset(1);
      for (int i = 0; i < 100; i++) begin
         if (i < 60 && i % 6 == 0) keys[0] = ~keys[0];
         if (i == 60) keys = 16'h0000;
         @(negedge clk);
         checks++;
         if (int_n !== 1'b1 || row_out !== 4'h0) begin
            errors++;
            $display("FAIL bounce t=%0t row_out=%h int_n=%b want 0 1", $time, row_out, int_n);
         end
         checks++;
         if (row_out !== exp_row || int_n !== exp_int_n || code_out !== exp_code) begin
            errors++;
            $display("FAIL bounce_model t=%0t got %h %b %h want %h %b %h", $time, row_out, int_n, code_out, exp_row, exp_int_n, exp_code);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lows[$];
      int highs[$];
      int run;
      logic prev;
      bit found;
      logic [3:0] want1, want2;
`ifdef KEY_CODE_EN
      want1 = 4'd3; want2 = 4'd9;
`else
      want1 = 4'd0; want2 = 4'd0;
`endif
      keys = 16'h0000;
      col_sel = 4'b0001;
      do_reset(1);
      keys = 16'h0008;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         checks++;
         if (row_out !== exp_row || int_n !== exp_int_n || code_out !== exp_code) begin
            errors++;
            $display("FAIL b2b_model t=%0t got %h %b %h want %h %b %h", $time, row_out, int_n, code_out, exp_row, exp_int_n, exp_code);
         end
         if (row_out === 4'b1000) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL b2b_wait row_out=%h want 8 within 40 clks", row_out);
      end
      checks++;
      if (int_n !== 1'b0 || code_out !== want1) begin
         errors++;
         $display("FAIL b2b_first int_n=%b code_out=%h want 0 %h", int_n, code_out, want1);
      end
      keys = 16'h0208;
      run = 1;
      prev = int_n;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         checks++;
         if (row_out !== exp_row || int_n !== exp_int_n || code_out !== exp_code) begin
            errors++;
            $display("FAIL b2b_model t=%0t got %h %b %h want %h %b %h", $time, row_out, int_n, code_out, exp_row, exp_int_n, exp_code);
         end
         if (int_n === prev) run++;
         else begin
            if (prev === 1'b0) lows.push_back(run);
            else highs.push_back(run);
            run = 1;
            prev = int_n;
            if (int_n === 1'b0) begin
               checks++;
               if (code_out !== want2) begin
                  errors++;
                  $display("FAIL b2b_second_code code_out=%h want %h", code_out, want2);
               end
            end
         end
      end
      checks++;
      if (lows.size() != 2) begin
         errors++;
         $display("FAIL b2b_pulses count=%0d want 2", lows.size());
      end else begin
         checks++;
         if (lows[0] != IL || lows[1] != IL || highs.size() < 1 || highs[0] < IL) begin
            errors++;
            $display("FAIL b2b_shape low0=%0d low1=%0d gap=%0d want %0d %0d >=%0d", lows[0], lows[1], (highs.size() > 0) ? highs[0] : -1, IL, IL, IL);
         end
      end
   endtask

   task automatic test_reset_mid_pulse();
      bit found;
      keys = 16'h0000;
      col_sel = 4'b0010;
      do_reset(1);
      keys = 16'h0020;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (int_n === 1'b0) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL midrst_wait int_n=%b want 0 within 40 clks", int_n);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      keys = 16'h0000;
      @(negedge clk);
      checks++;
      if (int_n !== 1'b1 || row_out !== 4'h0 || code_out !== 4'h0) begin
         errors++;
         $display("FAIL midrst_now int_n=%b row_out=%h code_out=%h want 1 0 0", int_n, row_out, code_out);
      end
      reset = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         checks++;
         if (int_n !== 1'b1 || row_out !== 4'h0) begin
            errors++;
            $display("FAIL midrst_after t=%0t int_n=%b row_out=%h want 1 0", $time, int_n, row_out);
         end
      end
   endtask

   task automatic test_all_keys();
      int low;
      keys = 16'h0000;
      col_sel = 4'hF;
      do_reset(1);
      keys = 16'hFFFF;
      low = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         checks++;
         if (row_out !== exp_row || int_n !== exp_int_n || code_out !== exp_code) begin
            errors++;
            $display("FAIL allkeys_model t=%0t got %h %b %h want %h %b %h", $time, row_out, int_n, code_out, exp_row, exp_int_n, exp_code);
         end
         if (int_n === 1'b0) low++;
      end
      checks++;
      if (low != IL || row_out !== 4'hF || code_out !== 4'h0) begin
         errors++;
         $display("FAIL allkeys low=%0d row_out=%h code_out=%h want %0d f 0", low, row_out, code_out, IL);
      end
   endtask

   task automatic test_random();
      int b;
      int hold;
      keys = 16'h0000;
      do_reset(1);
      for (int seg = 0; seg < 60; seg++) begin
         b = $urandom_range(0, 15);
         case ($urandom_range(0, 3))
            0: keys = 16'($urandom);
            1: keys[b] = 1'b1;
            2: keys[b] = 1'b0;
            default: keys[b] = ~keys[b];
         endcase
         hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : $urandom_range(20, 40);
         repeat (hold) begin
            col_sel = 4'($urandom);
            @(negedge clk);
            checks++;
            if (row_out !== exp_row || int_n !== exp_int_n || code_out !== exp_code) begin
               errors++;
               $display("FAIL random_model t=%0t got %h %b %h want %h %b %h", $time, row_out, int_n, code_out, exp_row, exp_int_n, exp_code);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_col_select();
      test_bounce();
      test_back_to_back();
      test_reset_mid_pulse();
      test_all_keys();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
